// File: rtl/reg_map_pkg.sv
// Sprite RAM address map, arbitration grant encoding and the queued pixel-write record.
// Shared by the arbiter and its write FIFO.
package reg_map_pkg;

    localparam logic [31:0] BASE_SPRITE      = 32'h0020_0000;
    localparam logic [31:0] R_SPRITE_STATUS  = BASE_SPRITE + 32'h0001_0000;
    localparam logic [31:0] R_SPRITE_RD_ADDR = BASE_SPRITE + 32'h0001_0004;
    localparam logic [31:0] R_SPRITE_RD_DATA = BASE_SPRITE + 32'h0001_0008;
    localparam logic [31:0] BUS_UNMAPPED     = 32'hdead_dead;

    localparam int IDX_W = 14;
    localparam int PIX_W = 18;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_DISP,
        GNT_READ,
        GNT_WRITE
    } ram_gnt_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [PIX_W-1:0] data;
    } pix_wr_t;

    // Pixel window covers only the first 64 KiB of the sprite block; registers sit above it.
    function automatic logic is_pixel_addr(input logic [31:0] addr);
        return (addr[31:20] == BASE_SPRITE[31:20]) && (addr[19:16] == 4'h0);
    endfunction

endpackage

// File: rtl/sprite_ram_arb_fifo.sv
// Synchronous FIFO holding bus pixel writes until the RAM has a free slot.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/sprite_ram_arb.sv
// Arbitrates one single-port sprite RAM between the display scan-out, a bus read port
// and a queue of bus pixel writes. Display always wins so scan-out never stalls.
module sprite_ram_arb
    import reg_map_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_50mhz,
    input  logic              rst,
    input  logic              disp_en,
    input  logic [IDX_W-1:0]  disp_idx,
    output logic [PIX_W-1:0]  disp_rdata,
    input  logic [31:0]       bus_addr,
    input  logic [31:0]       bus_wdata,
    input  logic              bus_wen,
    input  logic              bus_ren,
    output logic [31:0]       bus_rdata,
    output logic [IDX_W-1:0]  ram_addr,
    output logic              ram_we,
    output logic [PIX_W-1:0]  ram_wdata,
    input  logic [PIX_W-1:0]  ram_rdata
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    ram_gnt_e          gnt;
    pix_wr_t           fifo_wdata, fifo_head;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic              pix_wr, status_wr, rdaddr_wr, overflow;
    logic [31:0]       status_word;
    logic              unused_bus;

    logic [IDX_W-1:0]  rd_addr_q, rd_addr_d;
    logic [PIX_W-1:0]  rd_data_q, rd_data_d;
    logic [PIX_W-1:0]  disp_rdata_q, disp_rdata_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_inflight_q, rd_inflight_d;
    logic              disp_inflight_q, disp_inflight_d;
    logic              ovf_q, ovf_d;

    // bus_ren has no side effects; upper write-data bits carry nothing for this block.
    assign unused_bus = ^{bus_ren, bus_wdata[31:18]};

    assign pix_wr     = bus_wen && is_pixel_addr(bus_addr);
    assign status_wr  = bus_wen && (bus_addr == R_SPRITE_STATUS);
    assign rdaddr_wr  = bus_wen && (bus_addr == R_SPRITE_RD_ADDR);
    assign fifo_wdata = {bus_addr[15:2], bus_wdata[PIX_W-1:0]};

    assign fifo_pop  = (gnt == GNT_WRITE);
    assign fifo_push = pix_wr && !rst && (!fifo_full || fifo_pop);
    assign overflow  = pix_wr && !rst && fifo_full && !fifo_pop;

    sync_fifo #(
        .WIDTH ($bits(pix_wr_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk_i   (clk_50mhz),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            rd_addr_q       <= '0;
            rd_data_q       <= '0;
            disp_rdata_q    <= '0;
            rd_pend_q       <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_inflight_q   <= 1'b0;
            disp_inflight_q <= 1'b0;
            ovf_q           <= 1'b0;
        end else begin
            rd_addr_q       <= rd_addr_d;
            rd_data_q       <= rd_data_d;
            disp_rdata_q    <= disp_rdata_d;
            rd_pend_q       <= rd_pend_d;
            rd_valid_q      <= rd_valid_d;
            rd_inflight_q   <= rd_inflight_d;
            disp_inflight_q <= disp_inflight_d;
            ovf_q           <= ovf_d;
        end
    end

    // Grant and next state. Nothing is granted while reset is held, so no RAM write lands then.
    always_comb begin
        gnt = GNT_IDLE;
        if (rst) begin
            gnt = GNT_IDLE;
        end else if (disp_en) begin
            gnt = GNT_DISP;
        end else if (rd_pend_q) begin
            gnt = GNT_READ;
        end else if (!fifo_empty) begin
            gnt = GNT_WRITE;
        end

        disp_inflight_d = (gnt == GNT_DISP);
        disp_rdata_d    = disp_inflight_q ? ram_rdata : disp_rdata_q;

        rd_addr_d     = rd_addr_q;
        rd_data_d     = rd_data_q;
        rd_pend_d     = rd_pend_q;
        rd_valid_d    = rd_valid_q;
        rd_inflight_d = (gnt == GNT_READ);
        // A fresh RD_ADDR supersedes any read already in flight for the old address.
        if (rdaddr_wr) begin
            rd_addr_d     = bus_wdata[IDX_W-1:0];
            rd_pend_d     = 1'b1;
            rd_valid_d    = 1'b0;
            rd_inflight_d = 1'b0;
        end else begin
            if (gnt == GNT_READ) begin
                rd_pend_d = 1'b0;
            end
            if (rd_inflight_q) begin
                rd_data_d  = ram_rdata;
                rd_valid_d = 1'b1;
            end
        end

        ovf_d = ovf_q;
        if (status_wr && bus_wdata[8]) begin
            ovf_d = 1'b0;
        end
        if (overflow) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        ram_addr  = fifo_head.idx;
        ram_wdata = fifo_head.data;
        ram_we    = 1'b0;
        case (gnt)
            GNT_DISP:  ram_addr = disp_idx;
            GNT_READ:  ram_addr = rd_addr_q;
            GNT_WRITE: ram_we   = 1'b1;
            default:   ram_we   = 1'b0;
        endcase

        status_word = {23'b0, ovf_q, rd_valid_q, rd_pend_q, 6'(fifo_level)};
        bus_rdata   = BUS_UNMAPPED;
        case (bus_addr)
            R_SPRITE_STATUS:  bus_rdata = status_word;
            R_SPRITE_RD_ADDR: bus_rdata = {{(32-IDX_W){1'b0}}, rd_addr_q};
            R_SPRITE_RD_DATA: bus_rdata = {{(32-PIX_W){1'b0}}, rd_data_q};
            default:          bus_rdata = BUS_UNMAPPED;
        endcase
    end

    assign disp_rdata = disp_rdata_q;

endmodule

// File: tb/tb_sprite_ram_arb.sv
// Directed bench for sprite_ram_arb: register table, then display/bus arbitration,
// overflow and reset corner sequences against a behavioural synchronous RAM.
module tb_sprite_ram_arb;

    localparam logic [31:0] A_STATUS = 32'h0021_0000;
    localparam logic [31:0] A_RDADDR = 32'h0021_0004;
    localparam logic [31:0] A_RDDATA = 32'h0021_0008;

    logic        clk_50mhz = 1'b0;
    logic        rst;
    logic        disp_en;
    logic [13:0] disp_idx;
    logic [17:0] disp_rdata;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_wen, bus_ren;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [17:0] ram_wdata;
    logic [17:0] ram_rdata;

    int total = 0;
    int bad   = 0;
    int clash_cnt = 0;
    int we_cnt    = 0;

    sprite_ram_arb #(.FIFO_DEPTH(4)) dut (
        .clk_50mhz  (clk_50mhz),
        .rst        (rst),
        .disp_en    (disp_en),
        .disp_idx   (disp_idx),
        .disp_rdata (disp_rdata),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wen    (bus_wen),
        .bus_ren    (bus_ren),
        .bus_rdata  (bus_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    // Behavioural RAM: unwritten locations return a fixed preload pattern.
    bit [17:0] mem     [16384];
    bit        wr_flag [16384];

    function automatic logic [17:0] init_val(input int a);
        if (a == 100) return 18'h2_1234;
        if (a >= 200 && a < 208) return 18'h1_0000 + 18'(a - 200) * 18'h111;
        return 18'h0;
    endfunction

    function automatic logic [17:0] mem_rd(input int a);
        return wr_flag[a] ? mem[a] : init_val(a);
    endfunction

    always @(posedge clk_50mhz) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            wr_flag[ram_addr] <= 1'b1;
        end
        ram_rdata <= wr_flag[ram_addr] ? mem[ram_addr] : init_val(int'(ram_addr));
    end

    always @(negedge clk_50mhz) begin
        if (disp_en && ram_we) clash_cnt++;
        if (ram_we) we_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        bus_addr  = a;
        bus_wdata = d;
        bus_wen   = w;
        bus_ren   = r;
    endtask

    task automatic next_cycle();
        @(posedge clk_50mhz);
        #1;
    endtask

    function automatic logic [31:0] pix_addr(input int idx);
        return 32'h0020_0000 + 32'(idx) * 32'd4;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
        logic        ren;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [13];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int lat;
        int got;
        int we_snap;

        vt[0]  = '{A_STATUS,       32'h0,         1'b0, 1'b1, 32'h0000_0000};
        vt[1]  = '{A_RDADDR,       32'h0,         1'b0, 1'b1, 32'h0000_0000};
        vt[2]  = '{A_RDDATA,       32'h0,         1'b0, 1'b1, 32'h0000_0000};
        vt[3]  = '{32'h0021_0010,  32'h0,         1'b0, 1'b1, 32'hdead_dead};
        vt[4]  = '{32'h0021_000c,  32'h0,         1'b0, 1'b1, 32'hdead_dead};
        vt[5]  = '{32'h0020_0014,  32'h0,         1'b0, 1'b1, 32'hdead_dead};
        vt[6]  = '{32'h0031_0000,  32'h0,         1'b0, 1'b1, 32'hdead_dead};
        vt[7]  = '{A_RDADDR,       32'hffff_0064, 1'b1, 1'b0, 32'h0000_0000};
        vt[8]  = '{A_STATUS,       32'h0,         1'b0, 1'b1, 32'h0000_0040};
        vt[9]  = '{A_STATUS,       32'h0,         1'b0, 1'b1, 32'h0000_0000};
        vt[10] = '{A_STATUS,       32'h0,         1'b0, 1'b1, 32'h0000_0080};
        vt[11] = '{A_RDDATA,       32'h0,         1'b0, 1'b1, 32'h0002_1234};
        vt[12] = '{A_RDADDR,       32'h0,         1'b0, 1'b1, 32'h0000_0064};

        rst = 1'b1;
        disp_en = 1'b0;
        disp_idx = '0;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        repeat (3) next_cycle();
        @(negedge clk_50mhz);
        chk("rst_ram_we", 32'(ram_we), 32'h0);
        chk("rst_disp_rdata", 32'(disp_rdata), 32'h0);
        next_cycle();
        rst = 1'b0;

        // Register table
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].addr, vt[i].wdata, vt[i].wen, vt[i].ren);
            @(negedge clk_50mhz);
            chk($sformatf("vec%0d", i), bus_rdata, vt[i].exp);
            next_cycle();
        end
        drive(32'h0, 32'h0, 1'b0, 1'b0);

        // Pixel write 0x3ffff to index 5, then read it back through RD_ADDR/RD_DATA
        drive(pix_addr(5), 32'hffff_ffff, 1'b1, 1'b0);
        lat = -1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_50mhz);
            if (lat < 0 && ram_we && ram_addr == 14'd5 && ram_wdata == 18'h3ffff) lat = i;
            next_cycle();
            drive(32'h0, 32'h0, 1'b0, 1'b0);
        end
        chk("pix5_we_within2", 32'(lat >= 1 && lat <= 2), 32'h1);
        drive(A_RDADDR, 32'd5, 1'b1, 1'b0);
        next_cycle();
        drive(A_STATUS, 32'h0, 1'b0, 1'b1);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_50mhz);
            if (bus_rdata[7]) begin
                got = 1;
                break;
            end
            next_cycle();
        end
        next_cycle();
        chk("rd5_valid_wait", 32'(got), 32'h1);
        drive(A_RDDATA, 32'h0, 1'b0, 1'b1);
        @(negedge clk_50mhz);
        chk("rd5_data", bus_rdata, 32'h0003_ffff);
        next_cycle();

        // Display every 4th cycle with a 6-deep write burst
        for (int c = 0; c < 24; c++) begin
            disp_en  = (c % 4 == 0);
            disp_idx = 14'(200 + c / 4);
            if (c >= 1 && c <= 6) drive(pix_addr(310 + (c - 1) % 3), 32'(256 + c - 1), 1'b1, 1'b0);
            else if (c == 7) drive(A_STATUS, 32'h0, 1'b0, 1'b1);
            else drive(32'h0, 32'h0, 1'b0, 1'b0);
            @(negedge clk_50mhz);
            if (c == 7) chk("burst_status", bus_rdata, 32'h0000_0082);
            if (c >= 2) chk($sformatf("disp_rdata_c%0d", c), 32'(disp_rdata),
                            32'h0001_0000 + 32'((c - 2) / 4) * 32'h111);
            next_cycle();
        end
        disp_en = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk("burst_order_310", 32'(mem_rd(310)), 32'h103);
        chk("burst_order_311", 32'(mem_rd(311)), 32'h104);
        chk("burst_order_312", 32'(mem_rd(312)), 32'h105);

        // Forced stall: display held, fifth write overflows
        disp_en  = 1'b1;
        disp_idx = 14'd0;
        for (int i = 0; i < 5; i++) begin
            drive(pix_addr(400 + i), 32'h2000 + 32'(i), 1'b1, 1'b0);
            next_cycle();
        end
        drive(A_STATUS, 32'h0, 1'b0, 1'b1);
        @(negedge clk_50mhz);
        chk("ovf_set", bus_rdata, 32'h0000_0184);
        next_cycle();
        drive(A_STATUS, 32'h100, 1'b1, 1'b0);
        next_cycle();
        drive(A_STATUS, 32'h0, 1'b0, 1'b1);
        @(negedge clk_50mhz);
        chk("ovf_clear", bus_rdata, 32'h0000_0084);
        next_cycle();
        disp_en = 1'b0;
        drive(pix_addr(405), 32'h2005, 1'b1, 1'b0);
        @(negedge clk_50mhz);
        chk("full_pop_we", 32'(ram_we), 32'h1);
        next_cycle();
        drive(A_STATUS, 32'h0, 1'b0, 1'b1);
        @(negedge clk_50mhz);
        chk("full_push_status", bus_rdata, 32'h0000_0084);
        next_cycle();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        repeat (8) next_cycle();
        chk("ovf_kept_400", 32'(mem_rd(400)), 32'h2000);
        chk("ovf_dropped_404", 32'(mem_rd(404)), 32'h0);
        chk("ovf_push_405", 32'(mem_rd(405)), 32'h2005);

        // RD_ADDR write in a display slot
        disp_en  = 1'b1;
        disp_idx = 14'd200;
        drive(A_RDADDR, 32'd201, 1'b1, 1'b0);
        next_cycle();
        disp_en = 1'b0;
        drive(A_STATUS, 32'h0, 1'b0, 1'b1);
        @(negedge clk_50mhz);
        chk("coinc_gnt_addr", 32'(ram_addr), 32'd201);
        chk("coinc_gnt_we", 32'(ram_we), 32'h0);
        chk("coinc_status1", bus_rdata, 32'h0000_0040);
        next_cycle();
        @(negedge clk_50mhz);
        chk("coinc_status2", bus_rdata, 32'h0000_0000);
        next_cycle();
        @(negedge clk_50mhz);
        chk("coinc_status3", bus_rdata, 32'h0000_0080);
        next_cycle();
        drive(A_RDDATA, 32'h0, 1'b0, 1'b1);
        @(negedge clk_50mhz);
        chk("coinc_data", bus_rdata, 32'h0001_0111);
        next_cycle();

        // Reset with three queued writes and a pending read
        disp_en  = 1'b1;
        disp_idx = 14'd205;
        for (int i = 0; i < 3; i++) begin
            drive(pix_addr(500 + i), 32'h3000 + 32'(i), 1'b1, 1'b0);
            next_cycle();
        end
        drive(A_RDADDR, 32'd7, 1'b1, 1'b0);
        next_cycle();
        drive(A_STATUS, 32'h0, 1'b0, 1'b1);
        @(negedge clk_50mhz);
        chk("pre_rst_status", bus_rdata, 32'h0000_0043);
        chk("pre_rst_disp", 32'(disp_rdata), 32'h0001_0555);
        next_cycle();
        we_snap = we_cnt;
        rst = 1'b1;
        disp_en = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk_50mhz);
        chk("rst_cycle_we", 32'(ram_we), 32'h0);
        next_cycle();
        rst = 1'b0;
        drive(A_STATUS, 32'h0, 1'b0, 1'b1);
        @(negedge clk_50mhz);
        chk("post_rst_status", bus_rdata, 32'h0);
        chk("post_rst_disp", 32'(disp_rdata), 32'h0);
        next_cycle();
        drive(A_RDDATA, 32'h0, 1'b0, 1'b1);
        @(negedge clk_50mhz);
        chk("post_rst_rddata", bus_rdata, 32'h0);
        next_cycle();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        repeat (8) next_cycle();
        chk("post_rst_no_we", 32'(we_cnt - we_snap), 32'h0);
        chk("post_rst_mem500", 32'(mem_rd(500)), 32'h0);
        chk("post_rst_mem502", 32'(mem_rd(502)), 32'h0);

        chk("disp_we_clash", 32'(clash_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
